// File: rtl/icache_direct.sv
// Direct-mapped, one-word-line instruction cache with single-outstanding refill.
// Hits respond one cycle after the request; a miss responds one cycle after mem_ready.
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        mem_need,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_ins
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {S_IDLE = 1'b0, S_MISS = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]         r_data [LINES];
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINES-1:0]    r_valid;

    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_mem_need;
    logic [31:0] r_mem_addr;
    logic        r_discard;

    logic        w_nxt_valid;
    logic [31:0] w_nxt_inst;
    logic [31:0] w_nxt_pc;
    logic        w_nxt_need;
    logic [31:0] w_nxt_addr;
    logic        w_nxt_discard;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_fill;
    logic                  w_unused;

    assign w_idx      = fetch_pc[2+INDEX_BITS-1:2];
    assign w_tag      = fetch_pc[31:2+INDEX_BITS];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // the latched miss address doubles as the pending pc/tag/index
    assign w_fill_idx = r_mem_addr[2+INDEX_BITS-1:2];
    assign w_fill_tag = r_mem_addr[31:2+INDEX_BITS];
    assign w_fill     = rdy_in && (r_state == S_MISS) && mem_ready;
    assign w_unused   = ^fetch_pc[1:0];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (fetch_req && !flush && !w_hit) w_state_nxt = S_MISS;
            S_MISS: if (mem_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_valid   = 1'b0;
        w_nxt_inst    = r_inst;
        w_nxt_pc      = r_inst_pc;
        w_nxt_need    = r_mem_need;
        w_nxt_addr    = r_mem_addr;
        w_nxt_discard = r_discard;
        case (r_state)
            S_IDLE: begin
                if (fetch_req && !flush) begin
                    if (w_hit) begin
                        w_nxt_valid = 1'b1;
                        w_nxt_inst  = r_data[w_idx];
                        w_nxt_pc    = {fetch_pc[31:2], 2'b00};
                    end else begin
                        w_nxt_need    = 1'b1;
                        w_nxt_addr    = {fetch_pc[31:2], 2'b00};
                        w_nxt_discard = 1'b0;
                    end
                end
            end
            S_MISS: begin
                if (mem_ready) begin
                    w_nxt_need    = 1'b0;
                    w_nxt_discard = 1'b0;
                    if (!r_discard && !flush) begin
                        w_nxt_valid = 1'b1;
                        w_nxt_inst  = mem_ins;
                        w_nxt_pc    = r_mem_addr;
                    end
                end else if (flush) begin
                    w_nxt_discard = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid      <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_mem_need   <= 1'b0;
            r_mem_addr   <= '0;
            r_discard    <= 1'b0;
        end else if (rdy_in) begin
            r_inst_valid <= w_nxt_valid;
            r_inst       <= w_nxt_inst;
            r_inst_pc    <= w_nxt_pc;
            r_mem_need   <= w_nxt_need;
            r_mem_addr   <= w_nxt_addr;
            r_discard    <= w_nxt_discard;
            if (w_fill) r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // payload arrays need no reset; the valid bits gate every use
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_data[w_fill_idx] <= mem_ins;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign mem_need   = r_mem_need;
    assign mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_icache_direct.sv
// Directed vector bench for icache_direct: table of per-cycle inputs and the
// registered outputs expected after that cycle's clock edge, plus an async-reset sequence.
module tb_icache_direct;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_need;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_ins;

    int checks = 0;
    int errors = 0;

    icache_direct dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .mem_need(mem_need), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_ins(mem_ins)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        mr;
        logic [31:0] mi;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        en;
        logic [31:0] ea;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic req, input logic [31:0] pc, input logic fl, input logic rdy,
                       input logic mr, input logic [31:0] mi, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic en, input logic [31:0] ea);
        vec_t v;
        v.req = req; v.pc = pc; v.fl = fl; v.rdy = rdy; v.mr = mr; v.mi = mi;
        v.ev = ev; v.ei = ei; v.ep = ep; v.en = en; v.ea = ea;
        vq.push_back(v);
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic fl, input logic rdy,
                         input logic mr, input logic [31:0] mi);
        fetch_req = req; fetch_pc = pc; flush = fl; rdy_in = rdy; mem_ready = mr; mem_ins = mi;
    endtask

    initial begin
        bit seen;
        //  req  pc       fl rdy mr  mi            ev  inst          pc       need addr
        add(1, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h000);
        for (int i = 0; i < 4; i++)
            add(1, 32'h000, 0, 1, 0, 32'h0,      0, 32'h0,         32'h0,   1, 32'h000);
        add(1, 32'h000, 0, 1, 1, 32'h00000013,   1, 32'h00000013,  32'h000, 0, 32'h000);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h000);
        add(1, 32'h000, 0, 1, 0, 32'h0,          1, 32'h00000013,  32'h000, 0, 32'h000);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h000);
        // conflict on index 0, then back-to-back hit on the refilled line
        add(1, 32'h100, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h100);
        add(1, 32'h100, 0, 1, 1, 32'hDEADBEEF,   1, 32'hDEADBEEF,  32'h100, 0, 32'h100);
        add(1, 32'h100, 0, 1, 0, 32'h0,          1, 32'hDEADBEEF,  32'h100, 0, 32'h100);
        add(1, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h000);
        add(1, 32'h000, 0, 1, 1, 32'h00000013,   1, 32'h00000013,  32'h000, 0, 32'h000);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h000);
        // flush mid-miss
        add(1, 32'h040, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h040);
        add(1, 32'h040, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h040);
        add(0, 32'h040, 1, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h040);
        add(0, 32'h040, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h040);
        add(0, 32'h040, 0, 1, 1, 32'h12345678,   0, 32'h0,         32'h0,   0, 32'h040);
        add(1, 32'h040, 0, 1, 0, 32'h0,          1, 32'h12345678,  32'h040, 0, 32'h040);
        add(0, 32'h040, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h040);
        add(1, 32'h040, 1, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h040);
        // flush in the same cycle as mem_ready
        add(1, 32'h080, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h080);
        add(0, 32'h080, 1, 1, 1, 32'hAAAA5555,   0, 32'h0,         32'h0,   0, 32'h080);
        add(1, 32'h080, 0, 1, 0, 32'h0,          1, 32'hAAAA5555,  32'h080, 0, 32'h080);
        // rdy low holds the pulse and ignores a would-be miss
        add(1, 32'h100, 0, 0, 0, 32'h0,          1, 32'hAAAA5555,  32'h080, 0, 32'h080);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h080);
        // rdy low during MISS, with flush that must be ignored
        add(1, 32'h0C4, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   1, 32'h0C4);
        for (int i = 0; i < 3; i++)
            add(1, 32'h0C4, 1, 0, 0, 32'h0,      0, 32'h0,         32'h0,   1, 32'h0C4);
        add(1, 32'h0C4, 0, 1, 1, 32'h11223344,   1, 32'h11223344,  32'h0C4, 0, 32'h0C4);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h0C4);
        add(1, 32'h0C7, 0, 1, 0, 32'h0,          1, 32'h11223344,  32'h0C4, 0, 32'h0C4);
        add(0, 32'h000, 0, 1, 0, 32'h0,          0, 32'h0,         32'h0,   0, 32'h0C4);

        rst_in = 1'b0;
        drive(0, 32'h0, 0, 1, 0, 32'h0);
        #2;
        chk("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset inst", inst, 32'h0);
        chk("reset inst_pc", inst_pc, 32'h0);
        chk("reset mem_need", {31'h0, mem_need}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        foreach (vq[k]) begin
            drive(vq[k].req, vq[k].pc, vq[k].fl, vq[k].rdy, vq[k].mr, vq[k].mi);
            @(posedge clk_in);
            #1;
            chk($sformatf("vec%0d inst_valid", k), {31'h0, inst_valid}, {31'h0, vq[k].ev});
            chk($sformatf("vec%0d mem_need", k), {31'h0, mem_need}, {31'h0, vq[k].en});
            chk($sformatf("vec%0d mem_addr", k), mem_addr, vq[k].ea);
            if (vq[k].ev) begin
                chk($sformatf("vec%0d inst", k), inst, vq[k].ei);
                chk($sformatf("vec%0d inst_pc", k), inst_pc, vq[k].ep);
            end
        end

        // async reset in the middle of a miss on 0x200 (index 0)
        drive(1, 32'h200, 0, 1, 0, 32'h0);
        @(posedge clk_in);
        #1;
        chk("pre-reset mem_need", {31'h0, mem_need}, 32'h1);
        chk("pre-reset mem_addr", mem_addr, 32'h200);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async mem_need", {31'h0, mem_need}, 32'h0);
        chk("async mem_addr", mem_addr, 32'h0);
        chk("async inst_pc", inst_pc, 32'h0);
        drive(0, 32'h0, 0, 1, 0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // 0x40 was cached before reset; it must now miss
        drive(1, 32'h040, 0, 1, 0, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(posedge clk_in);
            #1;
            if (inst_valid) chk("post-reset stale hit", 32'h1, 32'h0);
            seen = mem_need;
        end
        chk("post-reset miss mem_need", {31'h0, seen}, 32'h1);
        chk("post-reset miss mem_addr", mem_addr, 32'h040);
        drive(1, 32'h040, 0, 1, 1, 32'h0BADF00D);
        @(posedge clk_in);
        #1;
        chk("post-reset refill valid", {31'h0, inst_valid}, 32'h1);
        chk("post-reset refill inst", inst, 32'h0BADF00D);
        chk("post-reset refill mem_need", {31'h0, mem_need}, 32'h0);
        drive(0, 32'h0, 0, 1, 0, 32'h0);
        @(posedge clk_in);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction-fetch unit and the memory controller.
- Serves fetch requests: hits in 1 cycle; misses go through a single-word refill over the controller's fetch port (iCache_need / ins_addr / ins_ready / ins).
- One outstanding miss at a time.
- A flush (branch mispredict / pipeline clear) cancels delivery of the response but never aborts a refill already in flight.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 one-word lines).
- TAG_BITS, 30-INDEX_BITS, tag width taken from fetch_pc[31:2+INDEX_BITS].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes all state and outputs
- fetch_req  input  1  fetch unit requests the word at fetch_pc; held with stable fetch_pc until inst_valid or flush
- fetch_pc  input  32  byte address; bits [1:0] ignored
- flush  input  1  discard the current request and any pending response
- inst_valid  output  1  one-cycle pulse: inst/inst_pc valid
- inst  output  32  instruction word
- inst_pc  output  32  pc the word belongs to ({fetch_pc[31:2],2'b00})
- mem_need  output  1  to controller iCache_need; refill request
- mem_addr  output  32  to controller ins_addr; word-aligned miss address
- mem_ready  input  1  from controller ins_ready; one-cycle pulse
- mem_ins  input  32  from controller ins; valid when mem_ready=1

Behaviour:
- Reset (rst_in=0, async): every valid bit cleared; state=IDLE; inst_valid=0, inst=0, inst_pc=0, mem_need=0, mem_addr=0, discard=0.
- rdy_in=0: no register changes, including the data/tag arrays; outputs hold.
- Lookup is combinational on index = fetch_pc[2+INDEX_BITS-1:2]. hit = valid[index] && tag[index]==fetch_pc[31:2+INDEX_BITS].
- IDLE:
  - fetch_req && !flush && hit: next cycle inst_valid=1, inst=data[index], inst_pc=fetch_pc. Latency 1.
  - fetch_req && !flush && miss: next cycle state=MISS, mem_need=1, mem_addr={fetch_pc[31:2],2'b00}; pending pc latched.
  - flush=1, or no fetch_req: inst_valid=0 next cycle; no refill started.
  - inst_valid is never high on two consecutive cycles for the same request. The cycle after a pulse, the fetch unit has either advanced fetch_pc or will re-request.
- MISS:
  - mem_need and mem_addr held stable until mem_ready=1.
  - On mem_ready: write data[idx]=mem_ins, tag[idx]=pending tag, valid[idx]=1. Next cycle mem_need=0 and state=IDLE.
  - If discard==0 and flush==0 that same cycle: next cycle inst_valid=1, inst=mem_ins, inst_pc=pending pc. Miss response latency = 1 cycle after mem_ready.
  - mem_need must be 0 for at least the cycle after the mem_ready pulse. The controller samples its request line again only from its idle state, so a new miss must not be issued earlier.
- Flush during MISS: sets discard=1; refill continues. The line is still written on mem_ready, with no inst_valid. discard clears on return to IDLE.
- flush in the same cycle as mem_ready: line written, no inst_valid.
- fetch_req ignored while in MISS; the fetch unit re-presents its request after inst_valid or after flush.
- Only one refill in flight. No stores ever write the cache; self-modifying code is unsupported.
- The back-to-back case is a hit on the just-refilled line: a request for the same pc one cycle after the refill's inst_valid must hit.

Test Plan:
- Reset, then fetch_req pc=0x0000_0000 -> miss; mem_need=1, mem_addr=0x0 next cycle. Drive mem_ready with mem_ins=0x00000013 after 5 cycles -> inst_valid pulse with inst=0x00000013, inst_pc=0x0; mem_need=0 the cycle after.
- Re-request pc=0x0 after the refill -> inst_valid the very next cycle, inst=0x00000013, mem_need stays 0.
- Conflict case, INDEX_BITS=6:
  - pc=0x0000_0100 maps to index 0 with a different tag -> miss, refill with mem_ins=0xDEADBEEF.
  - Refetch pc=0x0 -> miss again (line evicted).
- Flush mid-miss: miss on pc=0x40, assert flush 2 cycles later, then mem_ready with mem_ins=0x12345678 -> no inst_valid. A subsequent fetch of 0x40 hits, returning 0x12345678.
- rdy_in low for 3 cycles during MISS, with mem_ready held off -> mem_need/mem_addr unchanged, no state change; operation resumes normally afterwards.
- Async reset asserted mid-MISS -> outputs clear immediately, without waiting for a clock edge. After release, a fetch of a previously cached pc misses (all valid bits cleared).
